// File: rtl/sel_sequencer_8.sv
// sel_sequencer_8: steps the 3-bit mux select from slot 0 to a latched last slot, showing each slot for a fixed time
// Ports: clock, reset_n (sync, active-low); start (run request, sampled only in IDLE);
//        abort (cancel run); last (final slot index, latched at start);
//        sel (mux select); show (slot being shown); busy (HOLD/GAP/FINISH);
//        done (one-cycle pulse at run completion).
// Optional: SEL_SEQ_LOOP_EN adds input loop; with loop=1 the run wraps to slot 0 instead of finishing.
module sel_sequencer_8 #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] last,
`ifdef SEL_SEQ_LOOP_EN
    input  logic       loop,
`endif
    output logic [2:0] sel,
    output logic       show,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, HOLD, GAP, FINISH} state_t;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       last_q;
    logic             slot_end;
    // A slot ends after its gap, or straight after the hold when there is no gap phase.
    assign slot_end = (cnt == '0) && (state == GAP || (state == HOLD && GAP_CYCLES == 0));
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            last_q <= '0;
            sel    <= '0;
            show   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
            show  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (slot_end) begin
                if (sel != last_q) begin
                    sel   <= sel + 3'd1;
                    cnt   <= HOLD_LOAD;
                    state <= HOLD;
                    show  <= 1'b1;
                end
`ifdef SEL_SEQ_LOOP_EN
                else if (loop) begin
                    sel   <= '0;
                    cnt   <= HOLD_LOAD;
                    state <= HOLD;
                    show  <= 1'b1;
                    done  <= 1'b1;
                end
`endif
                else begin
                    state <= FINISH;
                    show  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        last_q <= last;
                        cnt    <= HOLD_LOAD;
                        state  <= HOLD;
                        sel    <= '0;
                        show   <= 1'b1;
                        busy   <= 1'b1;
                    end
                    // cnt==0 here implies a gap phase exists; the no-gap case is handled by slot_end.
                    HOLD: if (cnt == '0) begin
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                        show  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    GAP: cnt <= cnt - CNT_W'(1);
                    FINISH: begin
                        state <= IDLE;
                        sel   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sel_sequencer_8.sv
// tb_sel_sequencer_8: scoreboard bench for sel_sequencer_8 (per-cycle expected outputs queued at stimulus time)
module tb_sel_sequencer_8;
    localparam int H = 4;
    localparam int G = 2;
    typedef struct packed {logic [2:0] sel; logic show; logic busy; logic done;} exp_t;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [2:0] last = 3'd0;
    logic [2:0] sel;
    logic show, busy, done;
    logic start0 = 1'b0;
    logic [2:0] last0 = 3'd0;
    logic [2:0] sel0;
    logic show0, busy0, done0;
`ifdef SEL_SEQ_LOOP_EN
    logic loop = 1'b0;
`endif
    exp_t q[$];
    exp_t e;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clock = ~clock;
    sel_sequencer_8 #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .last(last),
`ifdef SEL_SEQ_LOOP_EN
        .loop(loop),
`endif
        .sel(sel), .show(show), .busy(busy), .done(done)
    );
    sel_sequencer_8 #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .CNT_W(8)) u_g0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .abort(1'b0), .last(last0),
`ifdef SEL_SEQ_LOOP_EN
        .loop(1'b0),
`endif
        .sel(sel0), .show(show0), .busy(busy0), .done(done0)
    );
    task automatic push_run(input int lst, input int hold, input int gap);
        for (int s = 0; s <= lst; s++) begin
            for (int i = 0; i < hold; i++) q.push_back(exp_t'({3'(s), 3'b110}));
            for (int i = 0; i < gap; i++) q.push_back(exp_t'({3'(s), 3'b010}));
        end
        q.push_back(exp_t'({3'(lst), 3'b011}));
        q.push_back(exp_t'(6'b0));
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_checks++;
        if ({sel, show, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_init: got %b expected %b", {sel, show, busy, done}, 6'b0);
        end
        reset_n = 1'b1;
        last = 3'd2;
        start = 1'b1;
        push_run(2, H, G);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel, show, busy, done} !== e) begin
                n_fail++;
                $display("FAIL reset_prerun c=%0d: got %b expected %b", c, {sel, show, busy, done}, e);
            end
            start = 1'b0;
        end
        q.delete();
        reset_n = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clock);
            n_checks++;
            if ({sel, show, busy, done} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_midrun c=%0d: got %b expected %b", c, {sel, show, busy, done}, 6'b0);
            end
        end
        reset_n = 1'b1;
    endtask
    task automatic test_normal();
        last = 3'd2;
        start = 1'b1;
        push_run(2, H, G);
        for (int c = 1; q.size() > 0; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel, show, busy, done} !== e) begin
                n_fail++;
                $display("FAIL normal c=%0d: got %b expected %b", c, {sel, show, busy, done}, e);
            end
            start = 1'b0;
        end
    endtask
    task automatic test_full();
        last = 3'd7;
        start = 1'b1;
        push_run(7, H, G);
        for (int c = 1; q.size() > 0; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel, show, busy, done} !== e) begin
                n_fail++;
                $display("FAIL full c=%0d: got %b expected %b", c, {sel, show, busy, done}, e);
            end
            if (c == 10) last = 3'd1;
            start = (c == 20);
        end
        start = 1'b0;
    endtask
    task automatic test_abort();
        last = 3'd2;
        start = 1'b1;
        push_run(2, H, G);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel, show, busy, done} !== e) begin
                n_fail++;
                $display("FAIL abort_pre c=%0d: got %b expected %b", c, {sel, show, busy, done}, e);
            end
            start = 1'b0;
        end
        q.delete();
        abort = 1'b1;
        repeat (12) q.push_back(exp_t'(6'b0));
        for (int c = 9; q.size() > 0; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel, show, busy, done} !== e) begin
                n_fail++;
                $display("FAIL abort_post c=%0d: got %b expected %b", c, {sel, show, busy, done}, e);
            end
            abort = 1'b0;
        end
        start = 1'b1;
        abort = 1'b1;
        repeat (3) q.push_back(exp_t'(6'b0));
        for (int c = 1; q.size() > 0; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel, show, busy, done} !== e) begin
                n_fail++;
                $display("FAIL start_with_abort c=%0d: got %b expected %b", c, {sel, show, busy, done}, e);
            end
            start = 1'b0;
            abort = 1'b0;
        end
    endtask
    task automatic test_gap0();
        last0 = 3'd1;
        start0 = 1'b1;
        push_run(1, 3, 0);
        for (int c = 1; q.size() > 0; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel0, show0, busy0, done0} !== e) begin
                n_fail++;
                $display("FAIL gap0 c=%0d: got %b expected %b", c, {sel0, show0, busy0, done0}, e);
            end
            start0 = 1'b0;
        end
    endtask
`ifdef SEL_SEQ_LOOP_EN
    task automatic test_loop();
        loop = 1'b1;
        last = 3'd1;
        start = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < H + G; i++)
                    if (r * 2 * (H + G) + s * (H + G) + i + 1 <= 27)
                        q.push_back(exp_t'({3'(s), 1'(i < H), 1'b1, 1'(r > 0 && s == 0 && i == 0)}));
        repeat (3) q.push_back(exp_t'(6'b0));
        for (int c = 1; q.size() > 0; c++) begin
            @(negedge clock);
            e = q.pop_front();
            n_checks++;
            if ({sel, show, busy, done} !== e) begin
                n_fail++;
                $display("FAIL loop c=%0d: got %b expected %b", c, {sel, show, busy, done}, e);
            end
            start = 1'b0;
            abort = (c == 27);
        end
        abort = 1'b0;
        loop = 1'b0;
    endtask
`endif
    initial begin
        test_reset();
        test_normal();
        test_full();
        test_abort();
        test_gap0();
`ifdef SEL_SEQ_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
